rvfi_reg_source: RTL and testbench

// - RVFI trace producer for register-consistency checks: accepts one instruction per handshake,

---
 rtl/rvfi_reg_source.sv | 177 +++++++++++++++++
 tb/tb_rvfi_reg_source.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rvfi_reg_source.sv
// RVFI trace producer for register-consistency checks: accepts one instruction per handshake,
// keeps a shadow register file and retires it on RVFI channel 0. Optional RVFI_REG_SOURCE_FAULT_EN.
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif

// state   | meaning
// ST_INIT | clearing x1..x31 one per cycle, no requests accepted
// ST_RUN  | accepting one instruction per cycle, retiring it the next cycle
module rvfi_reg_source #(
    parameter bit ZERO_INIT = 1'b1,
    localparam int NRET = `RISCV_FORMAL_NRET,
    localparam int XLEN = `RISCV_FORMAL_XLEN
) (
    input  logic                   clock,
    input  logic                   resetn,
`ifdef RVFI_REG_SOURCE_FAULT_EN
    input  logic                   fault_inject,
`endif
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_insn,
    input  logic [XLEN-1:0]        req_pc,
    input  logic [4:0]             req_rs1_addr,
    input  logic [4:0]             req_rs2_addr,
    input  logic [4:0]             req_rd_addr,
    input  logic [XLEN-1:0]        req_rd_wdata,
    output logic [NRET-1:0]        rvfi_valid,
    output logic [NRET*8-1:0]      rvfi_order,
    output logic [NRET*32-1:0]     rvfi_insn,
    output logic [NRET-1:0]        rvfi_trap,
    output logic [NRET-1:0]        rvfi_halt,
    output logic [NRET-1:0]        rvfi_intr,
    output logic [NRET*2-1:0]      rvfi_mode,
    output logic [NRET*2-1:0]      rvfi_ixl,
    output logic [NRET*5-1:0]      rvfi_rs1_addr,
    output logic [NRET*5-1:0]      rvfi_rs2_addr,
    output logic [NRET*XLEN-1:0]   rvfi_rs1_rdata,
    output logic [NRET*XLEN-1:0]   rvfi_rs2_rdata,
    output logic [NRET*5-1:0]      rvfi_rd_addr,
    output logic [NRET*XLEN-1:0]   rvfi_rd_wdata,
    output logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
    output logic [NRET*XLEN-1:0]   rvfi_pc_wdata,
    output logic [NRET*XLEN-1:0]   rvfi_mem_addr,
    output logic [NRET*XLEN/8-1:0] rvfi_mem_rmask,
    output logic [NRET*XLEN/8-1:0] rvfi_mem_wmask,
    output logic [NRET*XLEN-1:0]   rvfi_mem_rdata,
    output logic [NRET*XLEN-1:0]   rvfi_mem_wdata
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state, state_next;
    logic [4:0]      init_idx;
    logic            init_clear;
    logic            accept;
    logic [7:0]      order_cnt;
    logic [XLEN-1:0] regs [0:31];
    logic [XLEN-1:0] rs1_val, rs2_val;

    logic            v0;
    logic [7:0]      order0;
    logic [31:0]     insn0;
    logic [4:0]      rs1_addr0, rs2_addr0, rd_addr0;
    logic [XLEN-1:0] rs1_rdata0, rs2_rdata0, rd_wdata0, pc_rdata0, pc_wdata0;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= ZERO_INIT ? ST_INIT : ST_RUN;
            init_idx <= 5'd1;
        end else begin
            state <= state_next;
            if (init_clear)
                init_idx <= init_idx + 5'd1;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        init_clear = 1'b0;
        case (state)
            ST_INIT: begin
                init_clear = 1'b1;
                if (init_idx == 5'd31)
                    state_next = ST_RUN;
            end
            ST_RUN:  req_ready = 1'b1;
            default: state_next = ST_RUN;
        endcase
        // Reset wins: no handshake and no clearing while resetn is low.
        if (!resetn) begin
            req_ready  = 1'b0;
            init_clear = 1'b0;
        end
    end

    assign accept = req_valid && req_ready;

    // Writes land on the accept edge, so the next instruction reads them directly
    // and an instruction with rsN == rd still sees the old value.
    always_ff @(posedge clock) begin
        if (init_clear)
            regs[init_idx] <= '0;
        else if (accept && req_rd_addr != 5'd0)
            regs[req_rd_addr] <= req_rd_wdata;
    end

    always_comb begin
        rs1_val = (req_rs1_addr == 5'd0) ? '0 : regs[req_rs1_addr];
        rs2_val = (req_rs2_addr == 5'd0) ? '0 : regs[req_rs2_addr];
`ifdef RVFI_REG_SOURCE_FAULT_EN
        if (fault_inject && req_rs1_addr != 5'd0)
            rs1_val[0] = ~rs1_val[0];
`endif
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            order_cnt  <= '0;
            v0         <= 1'b0;
            order0     <= '0;
            insn0      <= '0;
            rs1_addr0  <= '0;
            rs2_addr0  <= '0;
            rd_addr0   <= '0;
            rs1_rdata0 <= '0;
            rs2_rdata0 <= '0;
            rd_wdata0  <= '0;
            pc_rdata0  <= '0;
            pc_wdata0  <= '0;
        end else begin
            v0 <= accept;
            if (accept) begin
                order_cnt  <= order_cnt + 8'd1;
                order0     <= order_cnt;
                insn0      <= req_insn;
                rs1_addr0  <= req_rs1_addr;
                rs2_addr0  <= req_rs2_addr;
                rd_addr0   <= req_rd_addr;
                rs1_rdata0 <= rs1_val;
                rs2_rdata0 <= rs2_val;
                rd_wdata0  <= (req_rd_addr == 5'd0) ? '0 : req_rd_wdata;
                pc_rdata0  <= req_pc;
                pc_wdata0  <= req_pc + XLEN'(4);
            end
        end
    end

    // Channel 0 occupies the low slice; higher channels are tied to zero.
    assign rvfi_valid     = NRET'(v0);
    assign rvfi_order     = (NRET*8)'(order0);
    assign rvfi_insn      = (NRET*32)'(insn0);
    assign rvfi_rs1_addr  = (NRET*5)'(rs1_addr0);
    assign rvfi_rs2_addr  = (NRET*5)'(rs2_addr0);
    assign rvfi_rd_addr   = (NRET*5)'(rd_addr0);
    assign rvfi_rs1_rdata = (NRET*XLEN)'(rs1_rdata0);
    assign rvfi_rs2_rdata = (NRET*XLEN)'(rs2_rdata0);
    assign rvfi_rd_wdata  = (NRET*XLEN)'(rd_wdata0);
    assign rvfi_pc_rdata  = (NRET*XLEN)'(pc_rdata0);
    assign rvfi_pc_wdata  = (NRET*XLEN)'(pc_wdata0);

    assign rvfi_trap      = '0;
    assign rvfi_halt      = '0;
    assign rvfi_intr      = '0;
    assign rvfi_mode      = '0;
    assign rvfi_ixl       = '0;
    assign rvfi_mem_addr  = '0;
    assign rvfi_mem_rmask = '0;
    assign rvfi_mem_wmask = '0;
    assign rvfi_mem_rdata = '0;
    assign rvfi_mem_wdata = '0;

endmodule

// File: tb/tb_rvfi_reg_source.sv
// Randomized bench for rvfi_reg_source against an array-based register model.
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif

module tb_rvfi_reg_source;
    localparam int NRET = `RISCV_FORMAL_NRET;
    localparam int XLEN = `RISCV_FORMAL_XLEN;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            fault_inject = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [31:0]     req_insn = '0;
    logic [XLEN-1:0] req_pc = '0;
    logic [4:0]      req_rs1_addr = '0, req_rs2_addr = '0, req_rd_addr = '0;
    logic [XLEN-1:0] req_rd_wdata = '0;

    logic [NRET-1:0]        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
    logic [NRET*8-1:0]      rvfi_order;
    logic [NRET*32-1:0]     rvfi_insn;
    logic [NRET*2-1:0]      rvfi_mode, rvfi_ixl;
    logic [NRET*5-1:0]      rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [NRET*XLEN-1:0]   rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [NRET*XLEN-1:0]   rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
    logic [NRET*XLEN-1:0]   rvfi_mem_rdata, rvfi_mem_wdata;
    logic [NRET*XLEN/8-1:0] rvfi_mem_rmask, rvfi_mem_wmask;

    always #5 clock = ~clock;

    rvfi_reg_source #(.ZERO_INIT(1'b1)) dut (
        .clock(clock), .resetn(resetn),
`ifdef RVFI_REG_SOURCE_FAULT_EN
        .fault_inject(fault_inject),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_insn(req_insn), .req_pc(req_pc),
        .req_rs1_addr(req_rs1_addr), .req_rs2_addr(req_rs2_addr), .req_rd_addr(req_rd_addr),
        .req_rd_wdata(req_rd_wdata),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural register values, retirement count, init cycles left.
    logic [XLEN-1:0] mregs [32];
    int              morder = 0;
    int              init_left = 31;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [XLEN-1:0] wd, input logic flt);
        logic            m_ready, acc;
        logic [XLEN-1:0] e_rs1, e_rs2, e_rdw, e_pc, e_pcw;
        logic [31:0]     e_insn;
        logic [7:0]      e_order;
        @(negedge clock);
        req_valid    = v;
        req_rs1_addr = rs1;
        req_rs2_addr = rs2;
        req_rd_addr  = rd;
        req_rd_wdata = wd;
        req_insn     = $urandom;
        req_pc       = XLEN'($urandom);
        fault_inject = flt;
        m_ready = resetn && (init_left == 0);
        #1;
        chk("req_ready", 64'(req_ready), 64'(m_ready));
        acc     = v && m_ready;
        e_rs1   = (rs1 == 5'd0) ? '0 : mregs[rs1];
        e_rs2   = (rs2 == 5'd0) ? '0 : mregs[rs2];
`ifdef RVFI_REG_SOURCE_FAULT_EN
        if (flt && rs1 != 5'd0) e_rs1 = e_rs1 ^ XLEN'(1);
`endif
        e_rdw   = (rd == 5'd0) ? '0 : wd;
        e_pc    = req_pc;
        e_pcw   = req_pc + XLEN'(4);
        e_insn  = req_insn;
        e_order = 8'(morder);
        @(posedge clock);
        #1;
        if (!resetn) begin
            morder    = 0;
            init_left = 31;
            for (int i = 0; i < 32; i++) mregs[i] = '0;
        end else begin
            if (init_left > 0) init_left--;
            if (acc) begin
                if (rd != 5'd0) mregs[rd] = wd;
                morder = (morder + 1) % 256;
            end
        end
        chk("rvfi_valid", 64'(rvfi_valid), 64'(acc));
        chk("zero_fields", 64'(|{rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode, rvfi_ixl,
                                 rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
                                 rvfi_mem_rdata, rvfi_mem_wdata}), 64'(0));
        if (!resetn) begin
            chk("rst_order", 64'(rvfi_order), 64'(0));
            chk("rst_rd_wdata", 64'(rvfi_rd_wdata), 64'(0));
            chk("rst_pc_rdata", 64'(rvfi_pc_rdata), 64'(0));
        end
        if (acc) begin
            chk("order", 64'(rvfi_order[7:0]), 64'(e_order));
            chk("insn", 64'(rvfi_insn[31:0]), 64'(e_insn));
            chk("pc_rdata", 64'(rvfi_pc_rdata[XLEN-1:0]), 64'(e_pc));
            chk("pc_wdata", 64'(rvfi_pc_wdata[XLEN-1:0]), 64'(e_pcw));
            chk("rs1_addr", 64'(rvfi_rs1_addr[4:0]), 64'(rs1));
            chk("rs2_addr", 64'(rvfi_rs2_addr[4:0]), 64'(rs2));
            chk("rs1_rdata", 64'(rvfi_rs1_rdata[XLEN-1:0]), 64'(e_rs1));
            chk("rs2_rdata", 64'(rvfi_rs2_rdata[XLEN-1:0]), 64'(e_rs2));
            chk("rd_addr", 64'(rvfi_rd_addr[4:0]), 64'(rd));
            chk("rd_wdata", 64'(rvfi_rd_wdata[XLEN-1:0]), 64'(e_rdw));
        end
    endtask

    task automatic rand_cycle(input int valid_pct);
        logic v;
        v = ($urandom_range(0, 99) < valid_pct);
        cycle(v, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), XLEN'($urandom), 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;

        // Reset, then 31 init cycles with requests offered but not taken.
        resetn = 1'b0;
        repeat (2) cycle(1'b1, 5'd1, 5'd2, 5'd3, XLEN'(32'h1234), 1'b0);
        resetn = 1'b1;
        repeat (31) rand_cycle(100);

        // Write-then-read, x0 read.
        cycle(1'b1, 5'd0, 5'd0, 5'd5, XLEN'(32'hDEADBEEF), 1'b0);
        cycle(1'b1, 5'd5, 5'd0, 5'd0, XLEN'(0), 1'b0);
        // rs1 == rd sees the old value, following read sees the new one.
        cycle(1'b1, 5'd0, 5'd0, 5'd7, XLEN'(32'h11), 1'b0);
        cycle(1'b1, 5'd7, 5'd0, 5'd7, XLEN'(32'h22), 1'b0);
        cycle(1'b1, 5'd7, 5'd7, 5'd0, XLEN'(0), 1'b0);
        // rd = x0 is discarded.
        cycle(1'b1, 5'd0, 5'd0, 5'd0, XLEN'(32'h55), 1'b0);
        cycle(1'b1, 5'd0, 5'd0, 5'd0, XLEN'(0), 1'b0);

`ifdef RVFI_REG_SOURCE_FAULT_EN
        cycle(1'b1, 5'd0, 5'd0, 5'd3, XLEN'(32'h10), 1'b0);
        cycle(1'b1, 5'd3, 5'd0, 5'd0, XLEN'(0), 1'b1);
        cycle(1'b1, 5'd3, 5'd0, 5'd0, XLEN'(0), 1'b0);
`endif

        // Random traffic, well over 256 accepts so the order counter wraps.
        repeat (600) rand_cycle(80);

        // Reset with an instruction in flight.
        cycle(1'b1, 5'd5, 5'd7, 5'd6, XLEN'(32'hA5A5), 1'b0);
        resetn = 1'b0;
        cycle(1'b1, 5'd6, 5'd7, 5'd6, XLEN'(32'h5A5A), 1'b0);
        resetn = 1'b1;
        repeat (31) rand_cycle(100);
        repeat (100) rand_cycle(70);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
